// File: rtl/video_bg_fetch_pkg.sv
// Shared constants for the background fetch sequencer: strobe bit indices,
// dot/line landmarks, v-register field positions and the v increment helpers.
package video_control_signals;

  // One-hot positions inside O_control
  localparam int CTRL_NT      = 0;
  localparam int CTRL_AT      = 1;
  localparam int CTRL_TILE_LO = 2;
  localparam int CTRL_TILE_HI = 3;

  // Dot landmarks
  localparam logic [8:0] DOT_FETCH_LO = 9'd1;
  localparam logic [8:0] DOT_Y_INC    = 9'd256;
  localparam logic [8:0] DOT_H_COPY   = 9'd257;
  localparam logic [8:0] DOT_V_CPY_LO = 9'd280;
  localparam logic [8:0] DOT_V_CPY_HI = 9'd304;
  localparam logic [8:0] DOT_PRE_LO   = 9'd321;
  localparam logic [8:0] DOT_PRE_HI   = 9'd336;
  localparam logic [8:0] DOT_DUMMY_LO = 9'd337;
  localparam logic [8:0] DOT_DUMMY_HI = 9'd340;
  localparam logic [8:0] LINE_PRE     = 9'd261;

  // v field slices: fineY[14:12] ntY[11] ntX[10] coarseY[9:5] coarseX[4:0]
  localparam int V_CX_LO = 0;
  localparam int V_CX_HI = 4;
  localparam int V_CY_LO = 5;
  localparam int V_CY_HI = 9;
  localparam int V_NTX   = 10;
  localparam int V_NTY   = 11;
  localparam int V_FY_LO = 12;
  localparam int V_FY_HI = 14;

  // Position of a dot inside its 8-dot tile fetch
  typedef enum logic [2:0] {
    PH_HI_DATA = 3'd0,
    PH_NT_ADDR = 3'd1,
    PH_NT_DATA = 3'd2,
    PH_AT_ADDR = 3'd3,
    PH_AT_DATA = 3'd4,
    PH_LO_ADDR = 3'd5,
    PH_LO_DATA = 3'd6,
    PH_HI_ADDR = 3'd7
  } fetch_phase_e;

  // Coarse X wraps into the horizontally adjacent nametable
  function automatic logic [14:0] coarse_x_inc(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[V_CX_HI:V_CX_LO] == 5'd31) begin
      r[V_CX_HI:V_CX_LO] = 5'd0;
      r[V_NTX]           = ~v[V_NTX];
    end else begin
      r[V_CX_HI:V_CX_LO] = v[V_CX_HI:V_CX_LO] + 5'd1;
    end
    return r;
  endfunction

  // Fine Y then coarse Y; row 29 flips the vertical nametable, row 31 wraps silently
  function automatic logic [14:0] y_inc(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[V_FY_HI:V_FY_LO] != 3'd7) begin
      r[V_FY_HI:V_FY_LO] = v[V_FY_HI:V_FY_LO] + 3'd1;
    end else begin
      r[V_FY_HI:V_FY_LO] = 3'd0;
      if (v[V_CY_HI:V_CY_LO] == 5'd29) begin
        r[V_CY_HI:V_CY_LO] = 5'd0;
        r[V_NTY]           = ~v[V_NTY];
      end else if (v[V_CY_HI:V_CY_LO] == 5'd31) begin
        r[V_CY_HI:V_CY_LO] = 5'd0;
      end else begin
        r[V_CY_HI:V_CY_LO] = v[V_CY_HI:V_CY_LO] + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/video_bg_fetch_vaddr.sv
// Scroll address register v: coarse X / Y increments, horizontal and
// vertical reloads from t, and the CPU-side full load (highest priority).
module video_bg_vaddr
  import video_control_signals::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [14:0] t_addr_i,
  input  logic        load_i,
  input  logic        inc_x_i,
  input  logic        inc_y_i,
  input  logic        copy_h_i,
  input  logic        copy_v_i,
  output logic [14:0] v_o
);

  logic [14:0] v_q, v_d;

  // Next v: X inc first so a same-dot Y inc sees it; CPU load overrides all
  always_comb begin
    v_d = v_q;
    if (inc_x_i) v_d = coarse_x_inc(v_d);
    if (inc_y_i) v_d = y_inc(v_d);
    if (copy_h_i) begin
      v_d[V_NTX]           = t_addr_i[V_NTX];
      v_d[V_CX_HI:V_CX_LO] = t_addr_i[V_CX_HI:V_CX_LO];
    end
    if (copy_v_i) begin
      v_d[V_FY_HI:V_NTY]   = t_addr_i[V_FY_HI:V_NTY];
      v_d[V_CY_HI:V_CY_LO] = t_addr_i[V_CY_HI:V_CY_LO];
    end
    if (load_i) v_d = t_addr_i;
  end

  // v register
  always_ff @(posedge clk_i) begin
    if (rst_i) v_q <= '0;
    else       v_q <= v_d;
  end

  assign v_o = v_q;

endmodule

// File: rtl/video_bg_fetch.sv
// Background fetch sequencer: decodes the 8-dot tile phase from the dot
// counter, drives NT/AT/pattern reads and the matching data strobes, and
// steers the v register updates.
// Optional feature macro: VIDEO_BG_FETCH_DUMMY_NT_EN (dummy NT reads at 337..340).
module video_bg_fetch
  import video_control_signals::*;
#(
  parameter int LAST_LINE     = 261,
  parameter int LAST_VIS_LINE = 239
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [8:0]  I_x_dot,
  input  logic [8:0]  I_y_line,
  input  logic [7:0]  I_ppuctrl,
  input  logic [7:0]  I_ppumask,
  input  logic [14:0] I_t_addr,
  input  logic        I_v_load,
  input  logic [7:0]  I_vid_data,
  output logic [13:0] O_vid_addr,
  output logic        O_vid_rd,
  output logic [15:0] O_control,
  output logic [1:0]  O_at_shift,
  output logic        O_shr_tile,
  output logic [14:0] O_v_addr
);

  logic [15:0] ctrl_q, ctrl_d;
  logic [13:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [1:0]  at_q, at_d;
  logic        shr_q, shr_d;
  logic [7:0]  tile_q, tile_d;
  logic        inc_x, inc_y, copy_h, copy_v;
  logic [14:0] v;

  logic        active, in_fetch;
  logic [13:0] nt_addr, at_addr, pt_lo, pt_hi;
  fetch_phase_e phase;

  logic unused_bits;
  assign unused_bits = ^{I_ppuctrl[7:5], I_ppuctrl[3:0], I_ppumask[7:5], I_ppumask[2:0]};

  assign active   = (|I_ppumask[4:3]) &&
                    ((I_y_line <= 9'(LAST_VIS_LINE)) || (I_y_line == 9'(LAST_LINE)));
  assign in_fetch = ((I_x_dot >= DOT_FETCH_LO) && (I_x_dot <= DOT_Y_INC)) ||
                    ((I_x_dot >= DOT_PRE_LO) && (I_x_dot <= DOT_PRE_HI));
  assign phase    = fetch_phase_e'(I_x_dot[2:0]);

  assign nt_addr = 14'h2000 | {2'b00, v[11:0]};
  assign at_addr = 14'h23C0 | {2'b00, v[11:10], 4'b0000, v[9:7], v[4:2]};
  assign pt_lo   = {1'b0, I_ppuctrl[4], tile_q, 1'b0, v[14:12]};
  assign pt_hi   = pt_lo | 14'h0008;

  // Phase decode: next-cycle strobes, bus address and v update requests
  always_comb begin
    ctrl_d = '0;
    rd_d   = 1'b0;
    addr_d = addr_q;
    at_d   = at_q;
    shr_d  = 1'b0;
    inc_x  = 1'b0;
    inc_y  = 1'b0;
    copy_h = 1'b0;
    copy_v = 1'b0;
    // Read data returns during the cycle the NT strobe is out
    tile_d = ctrl_q[CTRL_NT] ? I_vid_data : tile_q;
    if (active) begin
      if (in_fetch) begin
        case (phase)
          PH_NT_ADDR: begin rd_d = 1'b1; addr_d = nt_addr; end
          PH_NT_DATA: ctrl_d[CTRL_NT] = 1'b1;
          PH_AT_ADDR: begin rd_d = 1'b1; addr_d = at_addr; end
          PH_AT_DATA: begin ctrl_d[CTRL_AT] = 1'b1; at_d = {v[6], v[1]}; end
          PH_LO_ADDR: begin rd_d = 1'b1; addr_d = pt_lo; end
          PH_LO_DATA: ctrl_d[CTRL_TILE_LO] = 1'b1;
          PH_HI_ADDR: begin rd_d = 1'b1; addr_d = pt_hi; end
          PH_HI_DATA: begin ctrl_d[CTRL_TILE_HI] = 1'b1; shr_d = 1'b1; inc_x = 1'b1; end
          default: ;
        endcase
      end
`ifdef VIDEO_BG_FETCH_DUMMY_NT_EN
      else if ((I_x_dot >= DOT_DUMMY_LO) && (I_x_dot <= DOT_DUMMY_HI) &&
               ((phase == PH_NT_ADDR) || (phase == PH_AT_ADDR))) begin
        rd_d   = 1'b1;
        addr_d = nt_addr;
      end
`else
      // Bus idles at the end of the line
`endif
      inc_y  = (I_x_dot == DOT_Y_INC);
      copy_h = (I_x_dot == DOT_H_COPY);
      copy_v = (I_y_line == LINE_PRE) && (I_x_dot >= DOT_V_CPY_LO) && (I_x_dot <= DOT_V_CPY_HI);
    end
  end

  // Output and tile-index registers
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      ctrl_q <= '0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      at_q   <= '0;
      shr_q  <= 1'b0;
      tile_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      at_q   <= at_d;
      shr_q  <= shr_d;
      tile_q <= tile_d;
    end
  end

  video_bg_vaddr u_vaddr (
    .clk_i    (I_clock),
    .rst_i    (I_reset),
    .t_addr_i (I_t_addr),
    .load_i   (I_v_load),
    .inc_x_i  (inc_x),
    .inc_y_i  (inc_y),
    .copy_h_i (copy_h),
    .copy_v_i (copy_v),
    .v_o      (v)
  );

  assign O_control  = ctrl_q;
  assign O_vid_rd   = rd_q;
  assign O_vid_addr = addr_q;
  assign O_at_shift = at_q;
  assign O_shr_tile = shr_q;
  assign O_v_addr   = v;

endmodule

// File: tb/tb_video_bg_fetch.sv
// Directed bench for video_bg_fetch: each task drives dots/lines and checks
// registered outputs 1ns after the edge against hand-computed values.
module tb_video_bg_fetch;
  import video_control_signals::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  x_dot = '0, y_line = '0;
  logic [7:0]  ppuctrl = 8'h10, ppumask = 8'h18;
  logic [14:0] t_addr = '0;
  logic        v_load = 1'b0;
  logic [7:0]  vid_data = '0;
  logic [13:0] vid_addr;
  logic        vid_rd;
  logic [15:0] control;
  logic [1:0]  at_shift;
  logic        shr_tile;
  logic [14:0] v_addr;

  int vecs = 0;
  int errs = 0;

  localparam logic [15:0] S_NT = 16'(1) << CTRL_NT;
  localparam logic [15:0] S_AT = 16'(1) << CTRL_AT;
  localparam logic [15:0] S_LO = 16'(1) << CTRL_TILE_LO;
  localparam logic [15:0] S_HI = 16'(1) << CTRL_TILE_HI;

  always #5 clk = ~clk;

  // Video memory: NT entry at 0x2000 holds tile 0x24, data one cycle after the read
  always @(posedge clk)
    vid_data <= vid_rd ? ((vid_addr == 14'h2000) ? 8'h24 : 8'h5A) : 8'h00;

  video_bg_fetch dut (
    .I_clock(clk), .I_reset(rst), .I_x_dot(x_dot), .I_y_line(y_line),
    .I_ppuctrl(ppuctrl), .I_ppumask(ppumask), .I_t_addr(t_addr), .I_v_load(v_load),
    .I_vid_data(vid_data), .O_vid_addr(vid_addr), .O_vid_rd(vid_rd), .O_control(control),
    .O_at_shift(at_shift), .O_shr_tile(shr_tile), .O_v_addr(v_addr)
  );

  task automatic tick(input logic [8:0] x, input logic [8:0] y);
    x_dot = x; y_line = y;
    @(posedge clk); #1;
  endtask

  // Load v through the CPU path at dot 0 (no fetch side effects)
  task automatic load_v(input logic [14:0] t);
    t_addr = t; v_load = 1'b1;
    tick(9'd0, 9'd300);
    v_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(0, 0); tick(0, 0); rst = 1'b0;
    load_v(15'h1234);
    for (int d = 1; d <= 5; d++) tick(9'(d), 9'd3);
    rst = 1'b1; tick(9'd6, 9'd3); tick(9'd7, 9'd3); rst = 1'b0;
    vecs++;
    if (control !== 16'h0 || vid_addr !== 14'h0 || v_addr !== 15'h0 || vid_rd !== 1'b0 ||
        at_shift !== 2'b0 || shr_tile !== 1'b0) begin
      errs++;
      $display("FAIL reset: ctrl=%h addr=%h v=%h rd=%b at=%b shr=%b want all 0",
               control, vid_addr, v_addr, vid_rd, at_shift, shr_tile);
    end
  endtask

  task automatic test_tile_fetch();
    logic        e_rd   [1:8];
    logic [13:0] e_addr [1:8];
    logic [15:0] e_ctrl [1:8];
    e_rd   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    e_addr = '{14'h2000, 14'h2000, 14'h23C0, 14'h23C0, 14'h1240, 14'h1240, 14'h1248, 14'h1248};
    e_ctrl = '{16'h0, S_NT, 16'h0, S_AT, 16'h0, S_LO, 16'h0, S_HI};
    ppuctrl = 8'h10; ppumask = 8'h18;
    load_v(15'h0000);
    for (int d = 1; d <= 8; d++) begin
      tick(9'(d), 9'd0);
      vecs++;
      if (vid_rd !== e_rd[d] || vid_addr !== e_addr[d] || control !== e_ctrl[d] ||
          shr_tile !== (d == 8)) begin
        errs++;
        $display("FAIL fetch dot %0d: rd=%b addr=%h ctrl=%h shr=%b want rd=%b addr=%h ctrl=%h shr=%b",
                 d, vid_rd, vid_addr, control, shr_tile, e_rd[d], e_addr[d], e_ctrl[d], d == 8);
      end
    end
    vecs++;
    if (v_addr !== 15'h0001) begin
      errs++; $display("FAIL fetch_v: v=%h want 0001", v_addr);
    end
  endtask

  task automatic test_at_shift();
    load_v(15'h0040);
    tick(9'd4, 9'd0);
    vecs++;
    if (at_shift !== 2'b10 || control !== S_AT) begin
      errs++; $display("FAIL at_shift: at=%b ctrl=%h want 10/%h", at_shift, control, S_AT);
    end
    for (int d = 5; d <= 8; d++) tick(9'(d), 9'd0);
    vecs++;
    if (at_shift !== 2'b10 || v_addr !== 15'h0041) begin
      errs++; $display("FAIL at_hold: at=%b v=%h want 10/0041", at_shift, v_addr);
    end
  endtask

  task automatic test_coarse_x_wrap();
    load_v(15'h001F); tick(9'd8, 9'd0);
    vecs++;
    if (v_addr !== 15'h0400) begin errs++; $display("FAIL cx_wrap: v=%h want 0400", v_addr); end
    load_v(15'h041F); tick(9'd16, 9'd0);
    vecs++;
    if (v_addr !== 15'h0000) begin errs++; $display("FAIL cx_wrap2: v=%h want 0000", v_addr); end
  endtask

  // Dot 256 is also a tile_hi phase, so coarse X steps by one alongside Y
  task automatic test_y_inc();
    load_v(15'h73A0); tick(9'd256, 9'd0);
    vecs++;
    if (v_addr !== 15'h0801) begin errs++; $display("FAIL y_row29: v=%h want 0801", v_addr); end
    load_v(15'h73E0); tick(9'd256, 9'd5);
    vecs++;
    if (v_addr !== 15'h0001) begin errs++; $display("FAIL y_row31: v=%h want 0001", v_addr); end
    load_v(15'h1000); tick(9'd256, 9'd5);
    vecs++;
    if (v_addr !== 15'h2001) begin errs++; $display("FAIL y_fine: v=%h want 2001", v_addr); end
  endtask

  task automatic test_copy();
    load_v(15'h0000);
    t_addr = 15'h7FFF;
    for (int d = 257; d <= 305; d++) begin
      tick(9'(d), 9'd261);
      if (d == 257 || d == 279) begin
        vecs++;
        if (v_addr !== 15'h041F) begin
          errs++; $display("FAIL hcopy dot %0d: v=%h want 041F", d, v_addr);
        end
      end
      if (d == 304) begin
        vecs++;
        if (v_addr !== 15'h7FFF) begin errs++; $display("FAIL vcopy: v=%h want 7FFF", v_addr); end
      end
    end
  endtask

  task automatic test_disabled();
    int bad;
    bad = 0;
    ppumask = 8'h00;
    load_v(15'h0005);
    for (int d = 0; d <= 340; d++) begin
      tick(9'(d), 9'd10);
      if (vid_rd !== 1'b0 || control !== 16'h0 || shr_tile !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL disabled_bus: %0d busy dots want 0", bad); end
    vecs++;
    if (v_addr !== 15'h0005) begin errs++; $display("FAIL disabled_v: v=%h want 0005", v_addr); end
    load_v(15'h1234);
    vecs++;
    if (v_addr !== 15'h1234) begin errs++; $display("FAIL disabled_load: v=%h want 1234", v_addr); end
    // Mid-line disable: strobe stops on the next cycle
    ppumask = 8'h08; load_v(15'h0000); tick(9'd1, 9'd0);
    ppumask = 8'h00; tick(9'd2, 9'd0);
    vecs++;
    if (control !== 16'h0) begin errs++; $display("FAIL midline_off: ctrl=%h want 0", control); end
    ppumask = 8'h18;
  endtask

  task automatic test_load_wins();
    load_v(15'h001F);
    t_addr = 15'h0555; v_load = 1'b1;
    tick(9'd256, 9'd0);
    v_load = 1'b0;
    vecs++;
    if (v_addr !== 15'h0555) begin errs++; $display("FAIL load_wins: v=%h want 0555", v_addr); end
  endtask

  task automatic test_window();
    logic exp_dummy;
`ifdef VIDEO_BG_FETCH_DUMMY_NT_EN
    exp_dummy = 1'b1;
`else
    exp_dummy = 1'b0;
`endif
    load_v(15'h0000);
    tick(9'd0, 9'd0);
    vecs++;
    if (vid_rd !== 1'b0) begin errs++; $display("FAIL dot0: rd=%b want 0", vid_rd); end
    tick(9'd321, 9'd0);
    vecs++;
    if (vid_rd !== 1'b1 || vid_addr !== 14'h2000) begin
      errs++; $display("FAIL dot321: rd=%b addr=%h want 1/2000", vid_rd, vid_addr);
    end
    tick(9'd337, 9'd0);
    vecs++;
    if (vid_rd !== exp_dummy) begin
      errs++; $display("FAIL dot337: rd=%b want %b", vid_rd, exp_dummy);
    end
    tick(9'd1, 9'd240);
    vecs++;
    if (vid_rd !== 1'b0) begin errs++; $display("FAIL line240: rd=%b want 0", vid_rd); end
    tick(9'd1, 9'd261);
    vecs++;
    if (vid_rd !== 1'b1) begin errs++; $display("FAIL line261: rd=%b want 1", vid_rd); end
  endtask

  initial begin
    test_reset();
    test_tile_fetch();
    test_at_shift();
    test_coarse_x_wrap();
    test_y_inc();
    test_copy();
    test_disabled();
    test_load_wins();
    test_window();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
